// File: rtl/fd_dly_pkg.sv
// Shared types and constants for the MC100EP195 delay-line programmer.
// Holds the delay word width, the word type, the sequencer states and a phase-width helper.
package fd_dly_pkg;

  localparam int c_DLY_WIDTH = 10;

  typedef logic [c_DLY_WIDTH-1:0] t_dly_word;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    LATCH,
    HOLD
  } t_prog_state;

  // The phase counter only has to reach the longest of the three timed phases.
  function automatic int f_phase_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fd_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector.
// The search starts at the channel after the last advanced grant.
module fd_rr_arbiter #(
  parameter int g_width = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [g_width-1:0] req_i,
  input  logic               adv_i,
  output logic [g_width-1:0] gnt_o
);

  localparam int c_PTR_W = (g_width > 1) ? $clog2(g_width) : 1;

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_idx;
  logic [c_PTR_W-1:0] w_next_ptr;
  logic               w_found;

  always_comb begin
    gnt_o   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < g_width; i++) begin
      w_idx = c_PTR_W'((int'(r_ptr) + i) % g_width);
      if (!w_found && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_next_ptr = r_ptr;
    for (int i = 0; i < g_width; i++) begin
      if (gnt_o[i]) w_next_ptr = c_PTR_W'((i + 1) % g_width);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (adv_i) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/fd_delay_line_programmer.sv
// Programs MC100EP195-class delay chips over a shared 10-bit bus with per-chip LEN strobes.
// Optional macro FD_DLY_READBACK_EN adds cur_dly_o, a per-channel shadow of committed values.
module fd_delay_line_programmer
  import fd_dly_pkg::*;
#(
  parameter int g_num_channels = 4,
  parameter int g_setup_cycles = 2,
  parameter int g_len_cycles   = 3,
  parameter int g_hold_cycles  = 2
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_i,
  input  logic [g_num_channels-1:0]             req_i,
  input  logic [c_DLY_WIDTH*g_num_channels-1:0] req_value_i,
  output logic [g_num_channels-1:0]             ack_o,
  output logic                                  busy_o,
  output logic [c_DLY_WIDTH-1:0]                dly_o,
  output logic [g_num_channels-1:0]             len_o
`ifdef FD_DLY_READBACK_EN
  ,
  output logic [c_DLY_WIDTH*g_num_channels-1:0] cur_dly_o
`endif
);

  localparam int c_PH_W = f_phase_width(g_setup_cycles, g_len_cycles, g_hold_cycles);

  t_prog_state               r_state;
  logic [c_PH_W-1:0]         r_phase;
  logic [g_num_channels-1:0] r_pending;
  t_dly_word                 r_pend_val [g_num_channels];
  logic [g_num_channels-1:0] r_gnt_oh;
  t_dly_word                 r_dly;
  logic [g_num_channels-1:0] r_len;
  logic [g_num_channels-1:0] r_ack;

  logic [g_num_channels-1:0] w_grant;
  logic                      w_advance;
  t_dly_word                 w_gnt_val;
  logic                      w_setup_done;
  logic                      w_latch_done;
  logic                      w_hold_done;

  assign w_advance    = (r_state == IDLE) && (|r_pending);
  assign w_setup_done = (r_state == SETUP) && (r_phase == c_PH_W'(g_setup_cycles - 1));
  assign w_latch_done = (r_state == LATCH) && (r_phase == c_PH_W'(g_len_cycles - 1));
  assign w_hold_done  = (r_state == HOLD)  && (r_phase == c_PH_W'(g_hold_cycles - 1));

  fd_rr_arbiter #(
    .g_width (g_num_channels)
  ) u_arb (
    .clk_i (clk_sys_i),
    .rst_i (rst_i),
    .req_i (r_pending),
    .adv_i (w_advance),
    .gnt_o (w_grant)
  );

  always_comb begin
    w_gnt_val = '0;
    for (int i = 0; i < g_num_channels; i++) begin
      if (w_grant[i]) w_gnt_val = w_gnt_val | r_pend_val[i];
    end
  end

  // A strobe in the grant cycle lands after the clear, so it becomes a fresh pending entry.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_pending <= '0;
      for (int i = 0; i < g_num_channels; i++) r_pend_val[i] <= '0;
    end else begin
      for (int i = 0; i < g_num_channels; i++) begin
        if (w_advance && w_grant[i]) r_pending[i] <= 1'b0;
        if (req_i[i]) begin
          r_pending[i]  <= 1'b1;
          r_pend_val[i] <= req_value_i[i*c_DLY_WIDTH +: c_DLY_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_gnt_oh <= '0;
      r_dly    <= '0;
      r_len    <= '0;
      r_ack    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_advance) begin
            r_gnt_oh <= w_grant;
            r_dly    <= w_gnt_val;
            r_phase  <= '0;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          if (w_setup_done) begin
            r_phase <= '0;
            r_len   <= r_gnt_oh;
            r_state <= LATCH;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        LATCH: begin
          if (w_latch_done) begin
            r_phase <= '0;
            r_len   <= '0;
            r_state <= HOLD;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        HOLD: begin
          if (w_hold_done) begin
            r_phase <= '0;
            r_ack   <= r_gnt_oh;
            r_state <= IDLE;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: begin
          r_phase <= '0;
          r_len   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign len_o  = r_len;
  assign dly_o  = r_dly;
  assign busy_o = (r_state != IDLE) || (|r_pending);

`ifdef FD_DLY_READBACK_EN
  logic [c_DLY_WIDTH*g_num_channels-1:0] r_cur_dly;

  // Shadow commits on the same edge that raises ack, so it is readable from the ack cycle.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_cur_dly <= '0;
    end else if (w_hold_done) begin
      for (int i = 0; i < g_num_channels; i++) begin
        if (r_gnt_oh[i]) r_cur_dly[i*c_DLY_WIDTH +: c_DLY_WIDTH] <= r_dly;
      end
    end
  end

  assign cur_dly_o = r_cur_dly;
`endif

endmodule

// File: tb/tb_fd_delay_line_programmer.sv
// Randomized and directed bench for fd_delay_line_programmer against a timeline-based model.
// Build with FD_DLY_READBACK_EN defined to also check cur_dly_o.
module tb_fd_delay_line_programmer;
  import fd_dly_pkg::*;

  localparam int N = 4;
  localparam int S = 2;
  localparam int L = 3;
  localparam int H = 2;
  localparam int T = S + L + H + 1;

  // clock / reset and DUT signals
  logic               clk_sys_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [N-1:0]       req_i = '0;
  logic [10*N-1:0]    req_value_i = '0;
  logic [N-1:0]       ack_o;
  logic               busy_o;
  logic [9:0]         dly_o;
  logic [N-1:0]       len_o;
`ifdef FD_DLY_READBACK_EN
  logic [10*N-1:0]    cur_dly_o;
`endif

  always #5 clk_sys_i = ~clk_sys_i;

  fd_delay_line_programmer #(
    .g_num_channels (N),
    .g_setup_cycles (S),
    .g_len_cycles   (L),
    .g_hold_cycles  (H)
  ) dut (
    .clk_sys_i   (clk_sys_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .req_value_i (req_value_i),
    .ack_o       (ack_o),
    .busy_o      (busy_o),
    .dly_o       (dly_o),
    .len_o       (len_o)
`ifdef FD_DLY_READBACK_EN
    ,
    .cur_dly_o   (cur_dly_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: a transfer decided in cycle g drives the bus from g+1,
  // LEN over [g+1+S, g+S+L] and ack at g+T.
  bit         m_pend [N];
  logic [9:0] m_val [N];
  logic [9:0] m_shadow [N];
  int         m_ptr;
  int         m_g;
  int         m_ch;
  logic [9:0] m_gval;
  logic [9:0] m_dly;
  logic [9:0] exp_q[$];

  int         ack_cnt [N];
  int         last_ack_cyc [N];
  logic [9:0] last_ack_dly [N];
  int         ack_order[$];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i]   = 1'b0;
      m_val[i]    = '0;
      m_shadow[i] = '0;
    end
    m_ptr  = 0;
    m_g    = -100;
    m_ch   = 0;
    m_gval = '0;
    m_dly  = '0;
    exp_q.delete();
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin
      ack_cnt[i]      = 0;
      last_ack_cyc[i] = -1;
      last_ack_dly[i] = '0;
    end
    ack_order.delete();
  endtask

  // driver: one clock cycle -- check outputs, advance model, drive inputs
  task automatic step(input logic [N-1:0] req, input logic [10*N-1:0] vals, input bit rst);
    logic [N-1:0]    e_ack;
    logic [N-1:0]    e_len;
    logic [10*N-1:0] e_shadow;
    bit              e_busy;
    bit              any_p;
    @(negedge clk_sys_i);
    e_ack = '0;
    e_len = '0;
    if (cyc == m_g + 1) m_dly = m_gval;
    if (cyc >= m_g + 1 + S && cyc <= m_g + S + L) e_len[m_ch] = 1'b1;
    if (cyc == m_g + T) begin
      e_ack[m_ch]    = 1'b1;
      m_shadow[m_ch] = m_dly;
      if (exp_q.size() > 0) check("ack_word", 64'(dly_o), 64'(exp_q.pop_front()));
    end
    any_p = 1'b0;
    for (int i = 0; i < N; i++) any_p |= m_pend[i];
    e_busy = (cyc >= m_g + 1 && cyc < m_g + T) || any_p;

    check("ack_o", 64'(ack_o), 64'(e_ack));
    check("len_o", 64'(len_o), 64'(e_len));
    check("dly_o", 64'(dly_o), 64'(m_dly));
    check("busy_o", 64'(busy_o), 64'(e_busy));
    check("len_onehot", 64'($countones(len_o) <= 1), 64'(1));
`ifdef FD_DLY_READBACK_EN
    for (int i = 0; i < N; i++) e_shadow[i*10 +: 10] = m_shadow[i];
    check("cur_dly_o", 64'(cur_dly_o), 64'(e_shadow));
`else
    e_shadow = '0;
`endif

    for (int i = 0; i < N; i++) begin
      if (ack_o[i]) begin
        ack_cnt[i]++;
        last_ack_cyc[i] = cyc;
        last_ack_dly[i] = dly_o;
        ack_order.push_back(i);
      end
    end

    if (rst) begin
      model_reset();
    end else begin
      if (cyc >= m_g + T && any_p) begin
        for (int k = 0; k < N; k++) begin
          int ch;
          ch = (m_ptr + k) % N;
          if (m_pend[ch] && cyc != m_g) begin
            m_g        = cyc;
            m_ch       = ch;
            m_gval     = m_val[ch];
            m_pend[ch] = 1'b0;
            m_ptr      = (ch + 1) % N;
            exp_q.push_back(m_val[ch]);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          m_pend[i] = 1'b1;
          m_val[i]  = vals[i*10 +: 10];
        end
      end
    end

    rst_i       = rst;
    req_i       = rst ? '0 : req;
    req_value_i = vals;
    cyc++;
  endtask

  function automatic logic [10*N-1:0] put(input logic [10*N-1:0] v, input int ch, input logic [9:0] x);
    logic [10*N-1:0] r;
    r = v;
    r[ch*10 +: 10] = x;
    return r;
  endfunction

  function automatic logic [10*N-1:0] rnd_vals();
    logic [10*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*10 +: 10] = 10'($urandom_range(0, 1023));
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int prev;
    logic [N-1:0] rq;
    logic [10*N-1:0] v;

    rst_i = 1'b1;
    repeat (3) @(posedge clk_sys_i);
    model_reset();
    clear_obs();

    // single request on ch1
    s = cyc;
    step(4'b0010, put('0, 1, 10'h155), 1'b0);
    repeat (12) step('0, '0, 1'b0);
    check("single_latency", 64'(last_ack_cyc[1] - s), 64'(9));
    check("single_ack_count", 64'(ack_cnt[1]), 64'(1));
    check("single_ack_word", 64'(last_ack_dly[1]), 64'(10'h155));

    // all four channels at once after reset
    step('0, '0, 1'b1);
    clear_obs();
    v = rnd_vals();
    step(4'b1111, v, 1'b0);
    repeat (40) step('0, '0, 1'b0);
    check("rr_count", 64'(ack_order.size()), 64'(4));
    for (int k = 0; k < 4 && k < ack_order.size(); k++) check("rr_order", 64'(ack_order[k]), 64'(k));
    check("rr_spacing", 64'(last_ack_cyc[3] - last_ack_cyc[0]), 64'(24));
    check("rr_ch3_word", 64'(last_ack_dly[3]), 64'(v[39:30]));

    // overwrite of a pending channel while ch0 is in flight
    step('0, '0, 1'b1);
    clear_obs();
    step(4'b0001, put('0, 0, 10'h0AB), 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step(4'b0100, put('0, 2, 10'h010), 1'b0);
    step('0, '0, 1'b0);
    step(4'b0100, put('0, 2, 10'h3FF), 1'b0);
    repeat (25) step('0, '0, 1'b0);
    check("ovw_ack_count", 64'(ack_cnt[2]), 64'(1));
    check("ovw_word", 64'(last_ack_dly[2]), 64'(10'h3FF));
    check("ovw_ch0_count", 64'(ack_cnt[0]), 64'(1));

    // fairness: ch0 keeps re-requesting while ch3 waits
    step('0, '0, 1'b1);
    clear_obs();
    step(4'b0001, put('0, 0, 10'h011), 1'b0);
    step('0, '0, 1'b0);
    step(4'b1000, put('0, 3, 10'h033), 1'b0);
    rq = '0;
    for (int k = 0; k < 40; k++) begin
      prev = ack_cnt[0];
      step(rq, put('0, 0, 10'($urandom_range(0, 1023))), 1'b0);
      rq = (ack_cnt[0] != prev) ? 4'b0001 : 4'b0000;
    end
    check("fair_count", 64'(ack_order.size() >= 3), 64'(1));
    if (ack_order.size() >= 3) begin
      check("fair_first", 64'(ack_order[0]), 64'(0));
      check("fair_second", 64'(ack_order[1]), 64'(3));
      check("fair_third", 64'(ack_order[2]), 64'(0));
    end
    repeat (12) step('0, '0, 1'b0);

    // reset while LEN is high
    step('0, '0, 1'b1);
    clear_obs();
    s = cyc;
    step(4'b0100, put('0, 2, 10'h1C3), 1'b0);
    repeat (4) step('0, '0, 1'b0);
    step('0, '0, 1'b1);
    repeat (15) step('0, '0, 1'b0);
    check("rst_no_ack", 64'(ack_cnt[2]), 64'(0));
    step(4'b0010, put('0, 1, 10'h2AA), 1'b0);
    repeat (12) step('0, '0, 1'b0);
    check("post_rst_ack", 64'(ack_cnt[1]), 64'(1));
    check("post_rst_word", 64'(last_ack_dly[1]), 64'(10'h2AA));

    // random traffic with occasional reset
    for (int k = 0; k < 500; k++) begin
      rq = '0;
      for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 7) == 0);
      step(rq, rnd_vals(), ($urandom_range(0, 149) == 0));
    end
    repeat (40) step('0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fd_delay_line_programmer.md
Name: fd_delay_line_programmer

Overview:
- Drives the shared 10-bit programming bus and per-channel LEN strobes of the MC100EP195-class programmable delay chips (one chip per output channel).
- Accepts per-channel set-delay requests from the register bank or timestamp logic, arbitrates them round-robin, and sequences setup, LEN pulse and hold on the shared bus.
- A transfer completes only after the chip has latched the value and data hold time has elapsed; the block then acks the requester.

Parameters:
- g_num_channels, 4, number of delay chips sharing the data bus (1..8)
- g_setup_cycles, 2, cycles dly_o is stable before len_o rises (>=1)
- g_len_cycles, 3, cycles len_o stays high (>=1)
- g_hold_cycles, 2, cycles dly_o is held after len_o falls (>=1)

Ports:
- clk_sys_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- req_i  in  g_num_channels  one-cycle request strobe per channel
- req_value_i  in  10*g_num_channels  requested tap count; channel n at bits [10n+9:10n], sampled on req_i[n]
- ack_o  out  g_num_channels  one-cycle completion pulse per channel
- busy_o  out  1  high when the FSM is not IDLE or any request is pending
- dly_o  out  10  shared delay-word bus to all chips
- len_o  out  g_num_channels  per-chip latch enable; chip loads while high

Behaviour:
- Reset (rst_i sampled high on clk_sys_i): FSM to IDLE; all pending flags cleared; dly_o=0, len_o=0, ack_o=0, busy_o=0; arbiter pointer at channel 0. Reset mid-transfer aborts it immediately (len_o low next cycle, no ack).
- Capture: req_i[n] high sets pending[n] and stores req_value_i[n] into pend_val[n]. A new strobe on an already-pending channel overwrites the value (latest wins); that channel gets a single ack.
- A strobe for the channel currently being transferred creates a new pending entry; the in-flight transfer is unaffected.
- FSM states: IDLE, SETUP, LATCH, HOLD.
- IDLE: if any pending, grant the round-robin winner. Search starts at the channel after the last one granted. On grant, clear its pending flag, register its value onto dly_o, and go to SETUP.
- SETUP: g_setup_cycles cycles, len_o=0. Then go to LATCH.
- LATCH: g_len_cycles cycles, len_o[granted]=1, all other len_o bits 0. Then go to HOLD.
- HOLD: g_hold_cycles cycles, len_o=0. Then return to IDLE with ack_o[granted]=1 for exactly that cycle.
- The IDLE cycle that carries the ack may also grant the next channel (back-to-back transfers).
- dly_o changes only on a grant and holds its last value between transfers.
- Only one len_o bit is ever high at a time.
- Latency from strobe to ack with no contention: 1 + g_setup_cycles + g_len_cycles + g_hold_cycles + 1 cycles. With defaults: strobe in cycle 0, ack in cycle 9.
- A request strobe in the same cycle as a grant decision is not visible to that decision; it is considered next IDLE.
- Phase counter width is $clog2 of the maximum phase length; it resets to 0 on each state entry.

Optional Feature:
- Macro FD_DLY_READBACK_EN.
- Defined: adds output port cur_dly_o (10*g_num_channels bits), a per-channel shadow of the last value committed. Channel n's shadow updates in the cycle ack_o[n] pulses and resets to 0.
- Undefined: port and shadow registers are absent; no other behaviour changes.

Decomposition:
- Package fd_dly_pkg:
  - constant c_DLY_WIDTH=10
  - typedef t_dly_word (logic [9:0])
  - enum t_prog_state {IDLE, SETUP, LATCH, HOLD}
- Sub-module fd_rr_arbiter: parameterised width; inputs are the request vector and an advance strobe; output is a one-hot grant with a rotating priority pointer.

Test Plan:
- Single request: req_i[1]=1 with value 10'h155 in cycle 0 -> dly_o=0x155 from cycle 2; len_o[1]=1 in cycles 4-6 only; ack_o[1] in cycle 9; busy_o high in cycles 1-8.
- Simultaneous requests on all 4 channels after reset -> grants in order 0,1,2,3 back-to-back; acks 8 cycles apart; no len_o overlap; dly_o stable across every len_o high window plus 2 hold cycles.
- Overwrite: ch2 strobed with 0x010 then 0x3FF while ch0 is in transfer -> ch2 programmed with 0x3FF and a single ack_o[2].
- Fairness: ch0 re-requests immediately after each ack while ch3 is pending -> ch3 is granted before ch0's second transfer.
- Reset asserted during LATCH -> next cycle len_o=0, dly_o=0, no ack, pending cleared; a new request after reset completes normally.
- With FD_DLY_READBACK_EN: program ch1=0x2AA -> cur_dly_o[19:10]=0x2AA from the ack cycle; other channels read 0.
